led_blink_bank: RTL and testbench
=================================

# led_blink_bank

Parametrised bank of independent LED channels, each with its own runtime-programmable period, output mode and PWM duty. All channels run on a single clock domain. Replaces the fixed free-running counter taps with a board-level status/indicator block that sits between the clock/reset fabric and the `LED` pins. Configuration arrives through a one-cycle write strobe driven from switch decode or a host register interface.

## Interface
Parameters:
- `N_CH`, 4: number of channels, 1..16.
- `CNT_W`, 24: width of the per-channel counter, divisor and duty.
- `DEF_DIV`, 12_499_999: divisor loaded at reset (default mode BLINK).
- `CH_W`, `$clog2(N_CH)` (minimum 1): width of the channel select.

Ports (one clock; reset is synchronous and active-low):
- `CLK` in 1: sole clock; all state changes on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cfg_we` in 1: one-cycle write strobe.
- `cfg_ch` in `CH_W`: target channel.
- `cfg_mode` in 2: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
- `cfg_div` in `CNT_W`: period length minus 1.
- `cfg_duty` in `CNT_W`: PWM high cycles per period.
- `sync_restart` in 1: clears every channel's counter and phase in the same cycle.
- `LED` out `N_CH`: registered channel outputs.
- `tick` out `N_CH`: one-cycle pulse on period wrap.
- `cfg_err` out 1: one-cycle pulse when a write targets `cfg_ch >= N_CH`.

## Operation
Per-channel state: `mode`, `div`, `duty`, counter `cnt`, and the `LED` register.

**Counting**
- In BLINK and PWM, `cnt` counts 0..`div`, giving a period of `div+1` cycles.
- When `cnt == div`, `cnt` wraps to 0 on the next edge.
- Unsigned compare; no overflow is possible because `cnt` never exceeds `div`.

**Modes**
- OFF: `cnt` held at 0, `LED` = 0, no ticks.
- ON: `cnt` held at 0, `LED` = 1, no ticks.
- BLINK: `LED` toggles on each wrap edge, so the LED period is `2*(div+1)` cycles.
- PWM: `LED` is registered from the next-state compare `cnt_next < duty`.
  - `duty` = 0 gives a constant 0.
  - `duty > div` gives a constant 1.
- `div` = 0 in BLINK: `LED` toggles every cycle and `tick` stays high.

**tick**
- `tick[i]` = 1 for the cycle following each wrap edge.
- Asserted only in BLINK and PWM.

**Configuration writes**
- On `cfg_we` with a valid `cfg_ch`, the channel's `mode`, `div` and `duty` are loaded.
- The same write sets `cnt` to 0, `LED` to 0 (1 if ON; PWM gives `duty != 0`), and `tick` to 0.
- Other channels are undisturbed.
- Invalid `cfg_ch`: no state changes and `cfg_err` pulses for one cycle.

**sync_restart**
- For all channels: `cnt` to 0, `tick` to 0, BLINK `LED` to 0, PWM `LED` to `duty != 0`.
- Configuration registers are unchanged.

**Simultaneous events**
- `cfg_we` and `sync_restart` in the same cycle: the write is applied and all channels restart, all aligned at `cnt` = 0.

**Reset**
- `rst_n` low at an edge: every channel becomes BLINK with `div` = `DEF_DIV`, `duty` = 0, `cnt` = 0.
- Outputs after reset: `LED` = 0, `tick` = 0, `cfg_err` = 0.
- Reset overrides `cfg_we` and `sync_restart`, including mid-period.

## Timing
- Writes take effect at the edge that samples `cfg_we`; new behaviour is visible on the outputs from the following cycle.
- BLINK after reset release (first edge with `rst_n` = 1 is edge 1):
  - `cnt` reaches `div` after edge `div`.
  - The first `LED` toggle occurs at edge `div+1`, with `tick` high for that cycle only.
- PWM: `LED` is high for exactly `duty` consecutive cycles starting at `cnt` = 0, in phase with `cnt`.
- `cfg_err`: asserted the cycle after the bad write, for exactly one cycle.
- No combinational paths from inputs to outputs.

## Structure
- Package `led_bank_pkg`:
  - Mode localparams `MODE_OFF` = 0, `MODE_ON` = 1, `MODE_BLINK` = 2, `MODE_PWM` = 3.
  - A 2-bit mode typedef.
- Sub-module `led_channel` (params `CNT_W`, `DEF_DIV`): holds the config registers, `cnt`, `LED` and `tick` for one channel. Inputs: `load`, `restart` and the config fields.
- Top level `led_blink_bank`:
  - Generates `N_CH` instances of `led_channel`.
  - Decodes `cfg_ch` into per-channel `load`.
  - Raises `cfg_err`.

## Test plan
- **Reset default** (`DEF_DIV` = 3): release reset → `LED[i]` toggles at edges 4, 8, 12…; `tick[i]` high only in those cycles; all channels identical.
- **PWM**: write ch1 PWM with `div` = 9, `duty` = 3 → `LED[1]` high 3 of every 10 cycles. Then `duty` = 0 → constant 0; `duty` = 12 → constant 1.
- **OFF/ON and isolation**: write ch0 OFF and ch2 ON → `LED[0]` = 0 and `LED[2]` = 1 with no ticks; ch3 phase is unchanged by both writes.
- **Alignment**: channels in BLINK with `div` = 4, 6 and 9 at random phases; pulse `sync_restart` → all `cnt` = 0 and `LED` = 0 the next cycle. First ticks follow 5, 7 and 10 cycles later.
- **Errors and edge cases**:
  - `N_CH` = 3, write to `cfg_ch` = 3 → `cfg_err` pulses once and no channel changes.
  - BLINK with `div` = 0 → `LED` toggles every cycle.
- **Reset mid-operation**: assert `rst_n` low mid-PWM, concurrent with `cfg_we` → after release all channels are BLINK with `DEF_DIV` and the write is discarded.

Source files
------------

// File: rtl/led_blink_bank_pkg.sv
// Shared definitions for the LED channel bank.
// Contents:
//   mode_t           2-bit channel mode encoding
//   MODE_*           mode values (OFF, ON, BLINK, PWM)
//   led_at_align()   LED level a channel shows on the cycle its counter is realigned to 0
package led_bank_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF   = 2'd0;
  localparam mode_t MODE_ON    = 2'd1;
  localparam mode_t MODE_BLINK = 2'd2;
  localparam mode_t MODE_PWM   = 2'd3;

  // At cnt == 0 a BLINK channel is in its low half-period and a PWM channel is high
  // whenever it has any duty at all.
  function automatic logic led_at_align(mode_t mode, logic duty_nz);
    return (mode == MODE_ON) || ((mode == MODE_PWM) && duty_nz);
  endfunction

endpackage

// File: rtl/led_blink_bank_if.sv
// Configuration bus for led_blink_bank.
// Signals:
//   cfg_we    one-cycle write strobe
//   cfg_ch    target channel
//   cfg_mode  channel mode (mode_t)
//   cfg_div   period length minus 1
//   cfg_duty  PWM high cycles per period
//   cfg_err   one-cycle pulse after a write to a non-existent channel
// Modports: master drives the write fields, slave (the bank) returns cfg_err.
interface led_blink_bank_if #(
  parameter int unsigned CH_W  = 2,
  parameter int unsigned CNT_W = 24
) ();
  import led_bank_pkg::*;

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  mode_t            cfg_mode;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_duty;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_ch, cfg_mode, cfg_div, cfg_duty,
    input  cfg_err
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_mode, cfg_div, cfg_duty,
    output cfg_err
  );

endinterface

// File: rtl/led_channel.sv
// One LED channel: config registers, period counter, registered LED and tick.
// Ports:
//   CLK        clock
//   rst_n      synchronous active-low reset (to BLINK, DEF_DIV, duty 0)
//   i_load     load i_mode/i_div/i_duty and realign the counter
//   i_restart  realign the counter keeping the current configuration
//   i_mode, i_div, i_duty  configuration fields taken on i_load
//   o_led      registered LED output
//   o_tick     high for the cycle following each period wrap (BLINK/PWM only)
module led_channel
  import led_bank_pkg::*;
#(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned DEF_DIV = 12_499_999
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_restart,
  input  mode_t            i_mode,
  input  logic [CNT_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_duty,
  output logic             o_led,
  output logic             o_tick
);

  mode_t            r_mode;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_duty;
  logic [CNT_W-1:0] r_cnt;
  logic             r_led;
  logic             r_tick;

  logic             w_wrap;
  logic [CNT_W-1:0] w_cnt_next;

  // cnt never exceeds div, so the equality compare is the whole wrap condition.
  assign w_wrap     = (r_cnt == r_div);
  assign w_cnt_next = w_wrap ? '0 : r_cnt + CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_mode <= MODE_BLINK;
      r_div  <= CNT_W'(DEF_DIV);
      r_duty <= '0;
      r_cnt  <= '0;
      r_led  <= 1'b0;
      r_tick <= 1'b0;
    end else if (i_load || i_restart) begin
      // A load alone and a load coinciding with restart end in the same aligned state.
      if (i_load) begin
        r_mode <= i_mode;
        r_div  <= i_div;
        r_duty <= i_duty;
        r_led  <= led_at_align(i_mode, |i_duty);
      end else begin
        r_led  <= led_at_align(r_mode, |r_duty);
      end
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      unique case (r_mode)
        MODE_OFF: begin
          r_cnt  <= '0;
          r_led  <= 1'b0;
          r_tick <= 1'b0;
        end
        MODE_ON: begin
          r_cnt  <= '0;
          r_led  <= 1'b1;
          r_tick <= 1'b0;
        end
        MODE_BLINK: begin
          r_cnt  <= w_cnt_next;
          r_led  <= r_led ^ w_wrap;
          r_tick <= w_wrap;
        end
        MODE_PWM: begin
          r_cnt  <= w_cnt_next;
          // Compare against the next count so LED stays in phase with cnt.
          r_led  <= (w_cnt_next < r_duty);
          r_tick <= w_wrap;
        end
      endcase
    end
  end

  assign o_led  = r_led;
  assign o_tick = r_tick;

endmodule

// File: rtl/led_blink_bank.sv
// Bank of N_CH independent LED channels with runtime-programmable mode/period/duty.
// Ports:
//   CLK           sole clock
//   rst_n         synchronous active-low reset
//   cfg           configuration bus (slave modport): write strobe, channel, fields, cfg_err
//   sync_restart  realigns every channel's counter and phase in the same cycle
//   LED           registered channel outputs
//   tick          per-channel one-cycle pulse after each period wrap
module led_blink_bank
  import led_bank_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned DEF_DIV = 12_499_999,
  parameter int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLK,
  input  logic             rst_n,
  led_blink_bank_if.slave  cfg,
  input  logic             sync_restart,
  output logic [N_CH-1:0]  LED,
  output logic [N_CH-1:0]  tick
);

  logic [N_CH-1:0] w_load;
  logic            w_bad_wr;
  logic            r_cfg_err;

  // Out-of-range channel numbers match no decode below, so a bad write touches nothing.
  assign w_bad_wr = cfg.cfg_we && (32'(cfg.cfg_ch) >= N_CH);

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_bad_wr;
    end
  end

  assign cfg.cfg_err = r_cfg_err;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_load[g] = cfg.cfg_we && (cfg.cfg_ch == CH_W'(g));

    led_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .CLK       (CLK),
      .rst_n     (rst_n),
      .i_load    (w_load[g]),
      .i_restart (sync_restart),
      .i_mode    (cfg.cfg_mode),
      .i_div     (cfg.cfg_div),
      .i_duty    (cfg.cfg_duty),
      .o_led     (LED[g]),
      .o_tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_led_blink_bank.sv
// Self-checking bench for led_blink_bank (3 channels, DEF_DIV = 3).
// The model tracks, per channel, the configuration and the number of edges since the
// channel was last aligned (reset, load or restart); outputs are derived arithmetically.
module tb_led_blink_bank;
  import led_bank_pkg::*;

  localparam int unsigned N_CH    = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DEF_DIV = 3;
  localparam int unsigned CH_W    = 2;

  logic            CLK = 1'b0;
  logic            rst_n;
  logic            sync_restart;
  logic [N_CH-1:0] LED;
  logic [N_CH-1:0] tick;

  led_blink_bank_if #(.CH_W(CH_W), .CNT_W(CNT_W)) bus ();

  led_blink_bank #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV),
    .CH_W    (CH_W)
  ) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .cfg          (bus),
    .sync_restart (sync_restart),
    .LED          (LED),
    .tick         (tick)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  int m_mode [N_CH];
  int m_div  [N_CH];
  int m_duty [N_CH];
  int m_t    [N_CH];
  bit m_err;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic m_led(int i);
    int p = m_div[i] + 1;
    case (m_mode[i])
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((m_t[i] / p) % 2) == 1;
      default: return (m_t[i] % p) < m_duty[i];
    endcase
  endfunction

  function automatic logic m_tick(int i);
    int p = m_div[i] + 1;
    return (m_mode[i] >= 2) && (m_t[i] > 0) && ((m_t[i] % p) == 0);
  endfunction

  // Applies the inputs sampled at this edge to the model.
  function automatic void m_update();
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        m_mode[i] = 2;
        m_div[i]  = DEF_DIV;
        m_duty[i] = 0;
        m_t[i]    = 0;
      end
      m_err = 1'b0;
      return;
    end
    m_err = bus.cfg_we && (int'(bus.cfg_ch) >= N_CH);
    for (int i = 0; i < N_CH; i++) begin
      bit ld;
      ld = bus.cfg_we && (int'(bus.cfg_ch) == i);
      if (ld) begin
        m_mode[i] = int'(bus.cfg_mode);
        m_div[i]  = int'(bus.cfg_div);
        m_duty[i] = int'(bus.cfg_duty);
      end
      if (ld || sync_restart) m_t[i] = 0;
      else                    m_t[i] = m_t[i] + 1;
    end
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int i = 0; i < N_CH; i++) begin
        check($sformatf("led[%0d]", i), 32'(LED[i]), 32'(m_led(i)));
        check($sformatf("tick[%0d]", i), 32'(tick[i]), 32'(m_tick(i)));
      end
      check("cfg_err", 32'(bus.cfg_err), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge CLK);
    m_update();
    #1;
  endtask

  task automatic wr(int ch, mode_t mode, int dv, int duty, bit rs = 1'b0);
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = CH_W'(ch);
    bus.cfg_mode = mode;
    bus.cfg_div  = CNT_W'(dv);
    bus.cfg_duty = CNT_W'(duty);
    sync_restart = rs;
    step();
    bus.cfg_we   = 1'b0;
    sync_restart = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    sync_restart = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_mode = MODE_OFF;
    bus.cfg_div  = '0;
    bus.cfg_duty = '0;

    // Reset default: BLINK, div 3 -> toggles at edges 4, 8, ...
    step();
    chk_en = 1'b1;
    step();
    check("rst_led", 32'(LED), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_err", 32'(bus.cfg_err), 32'h0);
    rst_n = 1'b1;
    repeat (3) step();
    check("def_e3_led", 32'(LED), 32'h0);
    step();
    check("def_e4_led", 32'(LED), 32'h7);
    check("def_e4_tick", 32'(tick), 32'h7);
    step();
    check("def_e5_led", 32'(LED), 32'h7);
    check("def_e5_tick", 32'(tick), 32'h0);
    repeat (3) step();
    check("def_e8_led", 32'(LED), 32'h0);
    check("def_e8_tick", 32'(tick), 32'h7);

    // PWM on ch1: div 9, duty 3, then duty 0 and duty 12.
    wr(1, MODE_PWM, 9, 3);
    check("pwm_t0_led1", 32'(LED[1]), 32'h1);
    repeat (3) step();
    check("pwm_t3_led1", 32'(LED[1]), 32'h0);
    repeat (20) step();
    wr(1, MODE_PWM, 9, 0);
    repeat (12) step();
    check("pwm_d0_led1", 32'(LED[1]), 32'h0);
    wr(1, MODE_PWM, 9, 12);
    repeat (10) step();
    check("pwm_d12_led1", 32'(LED[1]), 32'h1);
    check("pwm_d12_tick1", 32'(tick[1]), 32'h1);

    // OFF / ON with ch1 keeping its phase.
    wr(0, MODE_OFF, 5, 0);
    wr(2, MODE_ON, 5, 0);
    check("off_led0", 32'(LED[0]), 32'h0);
    check("on_led2", 32'(LED[2]), 32'h1);
    repeat (10) step();
    check("offon_ticks", 32'({tick[2], tick[0]}), 32'h0);

    // Alignment: BLINK div 4/6/9 at different phases, then sync_restart.
    wr(0, MODE_BLINK, 4, 0);
    repeat (3) step();
    wr(1, MODE_BLINK, 6, 0);
    repeat (2) step();
    wr(2, MODE_BLINK, 9, 0);
    repeat (7) step();
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    check("align_led", 32'(LED), 32'h0);
    check("align_tick", 32'(tick), 32'h0);
    repeat (5) step();
    check("align_t5_tick", 32'(tick), 32'h1);
    check("align_t5_led", 32'(LED), 32'h1);
    repeat (2) step();
    check("align_t7_tick", 32'(tick), 32'h2);
    check("align_t7_led", 32'(LED), 32'h3);
    repeat (3) step();
    check("align_t10_tick", 32'(tick), 32'h5);
    check("align_t10_led", 32'(LED), 32'h6);

    // Write together with sync_restart.
    wr(1, MODE_BLINK, 2, 0, 1'b1);
    check("wr_rs_led", 32'(LED), 32'h0);
    repeat (12) step();

    // Bad channel write.
    wr(3, MODE_ON, 1, 1);
    check("err_pulse", 32'(bus.cfg_err), 32'h1);
    step();
    check("err_clear", 32'(bus.cfg_err), 32'h0);

    // BLINK div 0: toggles every cycle, tick stays high.
    wr(0, MODE_BLINK, 0, 0);
    step();
    check("div0_e1_led0", 32'(LED[0]), 32'h1);
    check("div0_e1_tick0", 32'(tick[0]), 32'h1);
    step();
    check("div0_e2_led0", 32'(LED[0]), 32'h0);
    check("div0_e2_tick0", 32'(tick[0]), 32'h1);
    repeat (6) step();

    // Reset mid-PWM concurrent with a write: the write is discarded.
    wr(1, MODE_PWM, 9, 5);
    repeat (4) step();
    rst_n        = 1'b0;
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = CH_W'(2);
    bus.cfg_mode = MODE_ON;
    step();
    rst_n      = 1'b1;
    bus.cfg_we = 1'b0;
    check("midrst_led", 32'(LED), 32'h0);
    check("midrst_tick", 32'(tick), 32'h0);
    repeat (4) step();
    check("midrst_e4_led", 32'(LED), 32'h7);
    check("midrst_e4_tick", 32'(tick), 32'h7);
    repeat (5) step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
